// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: per-stage enables/flushes,
// Exec operand forwarding, load-use and branch squash, and data-memory freeze with timeout.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] dec_rs,
  input  logic [REG_ADDR_W-1:0] dec_rt,
  input  logic                  dec_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_branch_taken,
  input  logic                  mem_mem_access,
  input  logic                  dmem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  pc_en,
  output logic                  ifd_en,
  output logic                  dex_en,
  output logic                  exm_en,
  output logic                  mwb_en,
  output logic                  flush_ifd,
  output logic                  flush_dex,
  output logic                  flush_exm,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  dmem_timeout,
  output logic [31:0]           stall_count
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             dmem_timeout_reg, dmem_timeout_next;
  logic [31:0]      stall_count_reg, stall_count_next;
  logic             freeze;
  logic             load_use;

  logic [REG_ADDR_W-1:0] ex_src [2];
  logic [1:0]            fwd_sel [2];

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  // Mem result is younger than WB, so it wins when both target the same register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      rst                                                         ? 2'b00 :
      (mem_reg_write && mem_rd != '0 && mem_rd == ex_src[gi])     ? 2'b01 :
      (wb_reg_write  && wb_rd  != '0 && wb_rd  == ex_src[gi])     ? 2'b10 :
                                                                    2'b00;
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  always_comb begin
    freeze = (state_reg == RUN && mem_mem_access && !dmem_ready) ||
             (state_reg == MEM_WAIT && !dmem_ready) ||
             (state_reg == FAULT);
    load_use = ex_mem_read && ex_rd != '0 &&
               (ex_rd == dec_rs || (dec_uses_rt && ex_rd == dec_rt));

    pc_en     = 1'b1;
    ifd_en    = 1'b1;
    dex_en    = 1'b1;
    exm_en    = 1'b1;
    mwb_en    = 1'b1;
    flush_ifd = 1'b0;
    flush_dex = 1'b0;
    flush_exm = 1'b0;

    if (rst || freeze) begin
      pc_en  = 1'b0;
      ifd_en = 1'b0;
      dex_en = 1'b0;
      exm_en = 1'b0;
      mwb_en = 1'b0;
    end else if (mem_branch_taken) begin
      flush_ifd = 1'b1;
      flush_dex = 1'b1;
      flush_exm = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      ifd_en    = 1'b0;
      flush_dex = 1'b1;
    end

    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN, MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          state_next    = (wait_cnt_reg == WAIT_LAST) ? FAULT : MEM_WAIT;
        end else begin
          wait_cnt_next = '0;
          state_next    = RUN;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = RUN;
    endcase

    dmem_timeout_next = dmem_timeout_reg | (state_next == FAULT);

    stall_count_next = stall_count_reg;
    if (!pc_en && stall_count_reg != 32'hFFFF_FFFF)
      stall_count_next = stall_count_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= '0;
      dmem_timeout_reg <= 1'b0;
      stall_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      dmem_timeout_reg <= dmem_timeout_next;
      stall_count_reg  <= stall_count_next;
    end
  end

  assign dmem_timeout = dmem_timeout_reg;
  assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each cycle pushes the expected enables, flushes,
// forwarding selects and post-edge counters, then pops and compares them against the DUT.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dec_rs, dec_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        dec_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write;
  logic        mem_branch_taken, mem_mem_access, dmem_ready, wb_reg_write;
  logic        pc_en, ifd_en, dex_en, exm_en, mwb_en;
  logic        flush_ifd, flush_dex, flush_exm;
  logic [1:0]  fwd_a, fwd_b;
  logic        dmem_timeout;
  logic [31:0] stall_count;

  typedef struct packed {
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] model_sc = 32'd0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_branch_taken(mem_branch_taken), .mem_mem_access(mem_mem_access),
    .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_en(pc_en), .ifd_en(ifd_en), .dex_en(dex_en), .exm_en(exm_en), .mwb_en(mwb_en),
    .flush_ifd(flush_ifd), .flush_dex(flush_dex), .flush_exm(flush_exm),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_timeout(dmem_timeout), .stall_count(stall_count)
  );

  task automatic set_idle();
    dec_rs = 5'd1; dec_rt = 5'd2; dec_uses_rt = 1'b0;
    ex_rs = 5'd10; ex_rt = 5'd11; ex_rd = 5'd12;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd20; mem_reg_write = 1'b0;
    mem_branch_taken = 1'b0; mem_mem_access = 1'b0; dmem_ready = 1'b1;
    wb_rd = 5'd21; wb_reg_write = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string name, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic to_exp);
    exp_t e;
    exp_t g;
    if (rst)
      model_sc = 32'd0;
    else if (!en[4] && model_sc != 32'hFFFF_FFFF)
      model_sc = model_sc + 32'd1;
    e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.sc = model_sc; e.to = to_exp;
    sb.push_back(e);
    #4;
    g = sb.pop_front();
    n_vec++;
    if ({pc_en, ifd_en, dex_en, exm_en, mwb_en} !== g.en) begin
      n_bad++;
      $display("FAIL %s enables got %b expected %b", name,
               {pc_en, ifd_en, dex_en, exm_en, mwb_en}, g.en);
    end
    n_vec++;
    if ({flush_ifd, flush_dex, flush_exm} !== g.fl) begin
      n_bad++;
      $display("FAIL %s flushes got %b expected %b", name,
               {flush_ifd, flush_dex, flush_exm}, g.fl);
    end
    n_vec++;
    if ({fwd_a, fwd_b} !== {g.fa, g.fb}) begin
      n_bad++;
      $display("FAIL %s fwd_a/fwd_b got %b/%b expected %b/%b", name, fwd_a, fwd_b, g.fa, g.fb);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (stall_count !== g.sc) begin
      n_bad++;
      $display("FAIL %s stall_count got %h expected %h", name, stall_count, g.sc);
    end
    n_vec++;
    if (dmem_timeout !== g.to) begin
      n_bad++;
      $display("FAIL %s dmem_timeout got %b expected %b", name, dmem_timeout, g.to);
    end
    $display("%s: en=%b fl=%b fwd=%b/%b sc=%0d to=%b", name,
             {pc_en, ifd_en, dex_en, exm_en, mwb_en}, {flush_ifd, flush_dex, flush_exm},
             fwd_a, fwd_b, stall_count, dmem_timeout);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
    mem_branch_taken = 1'b1;
    step("reset_forced", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
    step("reset_hold", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    set_idle();
    step("reset_release", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_forwarding();
    set_idle();
    ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1; wb_rd = 5'd3; wb_reg_write = 1'b1;
    step("fwd_mem_priority", 5'b11111, 3'b000, 2'b01, 2'b00, 1'b0);
    mem_reg_write = 1'b0;
    step("fwd_wb", 5'b11111, 3'b000, 2'b10, 2'b00, 1'b0);
    ex_rs = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    step("fwd_r0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    ex_rs = 5'd4; ex_rt = 5'd9; mem_rd = 5'd9; wb_rd = 5'd4;
    step("fwd_b_mem_a_wb", 5'b11111, 3'b000, 2'b10, 2'b01, 1'b0);
  endtask

  task automatic test_load_use();
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; dec_rs = 5'd5;
    step("lu_rs", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
    ex_mem_read = 1'b0;
    step("lu_after", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    ex_mem_read = 1'b1; dec_rs = 5'd2; dec_rt = 5'd5; dec_uses_rt = 1'b1;
    step("lu_rt", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
    dec_uses_rt = 1'b0;
    step("lu_rt_unused", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    ex_rd = 5'd0; dec_rs = 5'd0;
    step("lu_r0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_branch();
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; dec_rs = 5'd5; mem_branch_taken = 1'b1;
    step("branch_over_lu", 5'b11111, 3'b111, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_mem_access = 1'b1; dmem_ready = 1'b1;
    step("mem_ready_first", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    dmem_ready = 1'b0; mem_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++)
      step($sformatf("mem_freeze%0d", i + 1), 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
    dmem_ready = 1'b1;
    step("mem_release_branch", 5'b11111, 3'b111, 2'b00, 2'b00, 1'b0);
    set_idle();
    step("mem_after_release", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_timeout();
    set_idle();
    mem_mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      step($sformatf("to_freeze%0d", i + 1), 5'b00000, 3'b000, 2'b00, 2'b00, (i == 3));
    step("to_fault", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
    dmem_ready = 1'b1; mem_mem_access = 1'b0;
    step("to_fault_ready", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
    rst = 1'b1;
    step("to_reset", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    step("to_after_reset", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_saturation();
    set_idle();
    dut.stall_count_reg = 32'hFFFF_FFFE;
    model_sc = 32'hFFFF_FFFE;
    ex_mem_read = 1'b1; ex_rd = 5'd7; dec_rs = 5'd7;
    for (int i = 0; i < 3; i++)
      step($sformatf("sat%0d", i + 1), 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the 5-stage pipeline (IF, Dec, Exec, Mem, WB). It drives per-stage pipeline-register enables and flushes, and selects Exec-stage operand forwarding. It detects load-use hazards and branches resolved in Mem, and freezes the pipeline while data memory is not ready, with a timeout. It sits beside the pipeline registers in the pipeline top and owns no datapath.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register index width
- `MEM_WAIT_MAX`, 15, maximum consecutive freeze cycles before fault (must be ≥1)

Ports, one clock, reset synchronous active-high:
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous reset, active-high
- `dec_rs`, `dec_rt` in REG_ADDR_W: source indices of the instruction in Dec
- `dec_uses_rt` in 1: Dec instruction reads rt
- `ex_rs`, `ex_rt` in REG_ADDR_W: source indices in Exec
- `ex_rd` in REG_ADDR_W: destination in Exec
- `ex_reg_write`, `ex_mem_read` in 1: Exec writes a register / is a load
- `mem_rd` in REG_ADDR_W; `mem_reg_write` in 1: Mem destination and write flag
- `mem_branch_taken` in 1: branch in Mem is taken
- `mem_mem_access` in 1: Mem instruction is a load or store
- `dmem_ready` in 1: data memory completes the access this cycle
- `wb_rd` in REG_ADDR_W; `wb_reg_write` in 1: WB destination and write flag
- `pc_en`, `ifd_en`, `dex_en`, `exm_en`, `mwb_en` out 1: load enables for PC, IF/Dec, Dec/Exec, Exec/Mem and Mem/WB
- `flush_ifd`, `flush_dex`, `flush_exm` out 1: load a bubble into that register (only honored when its enable is 1)
- `fwd_a`, `fwd_b` out 2: Exec operand select. 00 = register file, 01 = Mem ALU output, 10 = WB data
- `dmem_timeout` out 1: sticky fault flag
- `stall_count` out 32: saturating count of cycles with pc_en=0

## Operation
- **Forwarding** (combinational):
  - `fwd_a` = 01 if mem_reg_write && mem_rd≠0 && mem_rd==ex_rs.
  - Otherwise `fwd_a` = 10 if wb_reg_write && wb_rd≠0 && wb_rd==ex_rs.
  - Otherwise `fwd_a` = 00.
  - `fwd_b` is identical, using ex_rt. Mem has priority over WB.
- **FSM** states: RUN, MEM_WAIT, FAULT.
- **freeze** = (RUN && mem_mem_access && !dmem_ready) || (MEM_WAIT && !dmem_ready) || FAULT.
  - While frozen, all five enables and all flushes are 0.
  - Branch and load-use are not evaluated while frozen; they are evaluated on the release cycle.
- **Branch** (not frozen, mem_branch_taken=1):
  - All enables are 1.
  - flush_ifd, flush_dex and flush_exm are 1, squashing the three younger instructions.
  - Branch has priority over load-use.
- **Load-use** (not frozen, no branch): triggers when ex_mem_read && ex_rd≠0 && (ex_rd==dec_rs || (dec_uses_rt && ex_rd==dec_rt)).
  - pc_en=0 and ifd_en=0.
  - dex_en=1 with flush_dex=1, inserting a bubble.
  - exm_en=1 and mwb_en=1.
  - The stall lasts exactly one cycle, because the load moves to Mem.
- **Otherwise**: all enables are 1 and all flushes are 0.
- **Transitions**:
  - RUN→MEM_WAIT on a freeze cycle.
  - MEM_WAIT→RUN when dmem_ready=1. The release cycle is not frozen.
  - MEM_WAIT→FAULT on the MEM_WAIT_MAX-th consecutive freeze cycle with dmem_ready=0.
  - FAULT exits only on rst.
- **wait_cnt** counts consecutive freeze cycles. It is 0 in RUN and increments on each freeze cycle. It is compared against MEM_WAIT_MAX-1 to trigger the FAULT transition.
- **dmem_timeout** is set on entry to FAULT and held until rst.
- **stall_count** increments on every cycle with pc_en=0 (load-use, freeze or FAULT). It saturates at 0xFFFF_FFFF.

## Timing
- Enables, flushes and fwd are combinational from inputs and state, with zero latency in the same cycle.
- Registered: state, wait_cnt, dmem_timeout, stall_count.
- Reset values: state=RUN, wait_cnt=0, dmem_timeout=0, stall_count=0.
- While rst=1, the combinational outputs are forced: enables=0, flushes=0, fwd=00.
- rst asserted mid-freeze or in FAULT returns the block to RUN on the next edge, with all counters and flags cleared.
- **Simultaneous events:**
  - Freeze and branch together: the branch is deferred and its flushes fire on the release cycle.
  - dmem_ready=1 on the first Mem cycle: no freeze and no state change.
  - A freeze ending in the same cycle wait_cnt would hit the limit with dmem_ready=1: release, not FAULT.
- With MEM_WAIT_MAX=1, a single not-ready cycle goes RUN→FAULT directly.

## Test plan
- **Forwarding:**
  - ex_rs=3, mem_rd=3 with mem_reg_write=1, wb_rd=3 with wb_reg_write=1 → fwd_a=01.
  - Same, but mem_reg_write=0 → fwd_a=10.
  - ex_rt=0 with matching rd → fwd_b=00.
- **Load-use:** ex_mem_read=1, ex_rd=5, dec_rs=5 → one cycle of pc_en=0, ifd_en=0, flush_dex=1. stall_count goes 0→1. Next cycle, with ex_mem_read=0, all enables are 1.
- **Branch vs load-use:** mem_branch_taken=1 while the load-use condition is also true → all enables 1; flush_ifd, flush_dex and flush_exm all 1; stall_count unchanged.
- **Memory wait:** mem_mem_access=1, dmem_ready low for 3 cycles then high → 3 cycles with all enables 0, release on the 4th cycle. stall_count=3 and dmem_timeout=0.
- **Timeout** (MEM_WAIT_MAX=4): dmem_ready held 0 → freeze cycles 1–4, dmem_timeout=1 from cycle 5. Pipeline stays frozen even after dmem_ready rises.
  - rst for one cycle → dmem_timeout=0, stall_count=0, normal enables.
- **Saturation:** preload via 2^32+ stalls is impractical. Force stall_count to 0xFFFF_FFFE by hierarchical deposit, then stall for 3 cycles → value holds at 0xFFFF_FFFF.
